// File: rtl/gain_step_pkg.sv
// Shared step codes, mode encodings and saturating adder for the gain step sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package gain_step_pkg;

    typedef enum logic [1:0] {
        INC_NONE = 2'b00,
        INC_UP   = 2'b01,
        INC_DN   = 2'b10
    } inc_code_t;

    localparam int MODE_LOCK = 0;
    localparam int MODE_OVR  = 1;
    localparam int MODE_CH0  = 2;

    // Symmetric saturating add: result clamped to [-lim, +lim].
    function automatic int sat_add(input int a, input int b, input int lim);
        int s;
        s = a + b;
        if (s > lim)
            return lim;
        if (s < -lim)
            return -lim;
        return s;
    endfunction

endpackage

// File: rtl/gain_step_emitter.sv
// One channel: accumulates routed click deltas and emits paced +1/-1 step codes (pos clamp under GAIN_STEP_TRACK_EN).
// Latency: delta lands in pend on edge 1, step code registered on edge 2; steps spaced HOLD+1 cycles.
// Backpressure: none; excess clicks queue in a saturating pending accumulator, flush clears it.
module gain_step_emitter
    import gain_step_pkg::*;
#(
    parameter int N_B  = 5,
    parameter int PW   = 6,
    parameter int HOLD = 3
`ifdef GAIN_STEP_TRACK_EN
    ,
    parameter int LB   = -9,
    parameter int UB   = 9
`endif
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic signed [N_B:0]  delta,
    output logic [1:0]           inc,
    output logic                 busy
`ifdef GAIN_STEP_TRACK_EN
    ,
    output logic signed [N_B-1:0] pos
`endif
);

    localparam int HW   = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam int PMAX = (2 ** (PW - 1)) - 1;

    logic signed [PW-1:0] pend;
    logic signed [PW-1:0] pend_nxt;
    logic [HW-1:0]        hold;
    logic                 fire;
    logic                 step_up;
    logic                 allow;
    int                   unit_i;

    // Decide whether a pending unit is consumed this cycle and compute the next accumulator value.
    always_comb begin
        fire    = (hold == '0) && (pend != '0);
        step_up = !pend[PW-1];
        allow   = 1'b1;
`ifdef GAIN_STEP_TRACK_EN
        // A step that would leave [LB,UB] still consumes its unit but produces no pulse.
        if (step_up)
            allow = (int'(pos) < UB);
        else
            allow = (int'(pos) > LB);
`endif
        unit_i   = fire ? (step_up ? 1 : -1) : 0;
        pend_nxt = PW'(sat_add(int'(pend), int'(delta) - unit_i, PMAX));
    end

    // Pending accumulator, hold pacing and registered step/busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
            hold <= '0;
            inc  <= INC_NONE;
            busy <= 1'b0;
`ifdef GAIN_STEP_TRACK_EN
            pos  <= '0;
`endif
        end else begin
            if (hold != '0)
                hold <= hold - HW'(1);
            inc <= INC_NONE;
            if (flush) begin
                pend <= '0;
                busy <= 1'b0;
            end else begin
                pend <= pend_nxt;
                busy <= (pend_nxt != '0);
                if (fire && allow) begin
                    inc  <= step_up ? INC_UP : INC_DN;
                    hold <= HW'(HOLD);
`ifdef GAIN_STEP_TRACK_EN
                    if (step_up)
                        pos <= pos + N_B'(1);
                    else
                        pos <= pos - N_B'(1);
`endif
                end
            end
        end
    end

endmodule

// File: rtl/gain_step_sequencer.sv
// Turns signed click-count changes into paced per-channel +1/-1 gain steps; GAIN_STEP_TRACK_EN adds clamped pos output.
// Latency: click change to first step pulse is 2 cycles; later steps every HOLD+1 cycles.
// Backpressure: none; multi-click jumps queue per channel, LOCK or an invalid mode flushes the queue.
module gain_step_sequencer
    import gain_step_pkg::*;
#(
    parameter int              N_B      = 5,
    parameter int              N_CH     = 4,
    parameter int              LB       = -9,
    parameter int              UB       = 9,
    parameter int              HOLD     = 3,
    parameter int              PW       = 6,
    parameter logic [N_CH-1:0] OVR_MASK = 4'b0011,
    localparam int             MW       = $clog2(N_CH + 2)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MW-1:0]         mode,
    input  logic signed [N_B-1:0] in_ovr,
    input  logic [N_CH*N_B-1:0]   in_ch,
    output logic [2*N_CH-1:0]     inc,
    output logic [N_CH-1:0]       busy
`ifdef GAIN_STEP_TRACK_EN
    ,
    output logic [N_CH*N_B-1:0]   pos
`endif
);

    logic signed [N_B-1:0] ovr_old;
    logic signed [N_B-1:0] ch_old [N_CH];
    logic signed [N_B-1:0] ch_in  [N_CH];
    logic                  primed;
    logic                  ovr_ok;
    logic [N_CH-1:0]       ch_ok;
    logic signed [N_B:0]   ovr_delta;
    logic signed [N_B:0]   ch_delta    [N_CH];
    logic signed [N_B:0]   route_delta [N_CH];
    logic                  flush;

    function automatic logic in_rng(input logic signed [N_B-1:0] v);
        return (int'(v) >= LB) && (int'(v) <= UB);
    endfunction

    // Range checks, per-source deltas against the last in-range value, and routing by mode.
    always_comb begin
        ovr_ok    = in_rng(in_ovr);
        ovr_delta = (primed && ovr_ok) ?
                    ({in_ovr[N_B-1], in_ovr} - {ovr_old[N_B-1], ovr_old}) : '0;
        flush     = (int'(mode) == MODE_LOCK) || (int'(mode) >= MODE_CH0 + N_CH);
        for (int k = 0; k < N_CH; k++) begin
            ch_in[k]       = signed'(in_ch[k*N_B +: N_B]);
            ch_ok[k]       = in_rng(ch_in[k]);
            ch_delta[k]    = (primed && ch_ok[k]) ?
                             ({ch_in[k][N_B-1], ch_in[k]} - {ch_old[k][N_B-1], ch_old[k]}) : '0;
            route_delta[k] = '0;
            if ((int'(mode) == MODE_OVR) && OVR_MASK[k])
                route_delta[k] = ovr_delta;
            else if (int'(mode) == MODE_CH0 + k)
                route_delta[k] = ch_delta[k];
        end
    end

    // Every source tracks its input whenever in range, whatever the mode; OOR freezes the reference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed  <= 1'b0;
            ovr_old <= '0;
            for (int k = 0; k < N_CH; k++)
                ch_old[k] <= '0;
        end else begin
            primed <= 1'b1;
            if (ovr_ok)
                ovr_old <= in_ovr;
            for (int k = 0; k < N_CH; k++)
                if (ch_ok[k])
                    ch_old[k] <= ch_in[k];
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        gain_step_emitter #(
            .N_B  (N_B),
            .PW   (PW),
            .HOLD (HOLD)
`ifdef GAIN_STEP_TRACK_EN
            ,
            .LB   (LB),
            .UB   (UB)
`endif
        ) u_emitter (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .delta (route_delta[k]),
            .inc   (inc[2*k +: 2]),
            .busy  (busy[k])
`ifdef GAIN_STEP_TRACK_EN
            ,
            .pos   (pos[k*N_B +: N_B])
`endif
        );
    end

endmodule

// File: tb/tb_gain_step_sequencer.sv
// Self-checking bench for gain_step_sequencer: expected step-code vectors are queued per cycle and compared as the DUT runs.
// Latency: bench expects first pulse 2 cycles after an input change, then one slot every 4 cycles.
// Backpressure: not applicable.
module tb_gain_step_sequencer;

    localparam int N_B  = 5;
    localparam int N_CH = 4;
    localparam int MW   = 3;
    localparam int SLOT = 4;
    localparam logic [1:0] UP = 2'b01;
    localparam logic [1:0] DN = 2'b10;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [MW-1:0]         mode;
    logic signed [N_B-1:0] in_ovr;
    logic [N_CH*N_B-1:0]   in_ch;
    logic [2*N_CH-1:0]     inc;
    logic [N_CH-1:0]       busy;
`ifdef GAIN_STEP_TRACK_EN
    logic [N_CH*N_B-1:0]   pos;
`endif

    int n_run  = 0;
    int n_fail = 0;
    logic [2*N_CH-1:0] exp_q [$];
    logic [2*N_CH-1:0] e;
    int cyc_i;

    always #5 clk = ~clk;

    gain_step_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .in_ovr (in_ovr),
        .in_ch  (in_ch),
        .inc    (inc),
        .busy   (busy)
`ifdef GAIN_STEP_TRACK_EN
        ,
        .pos    (pos)
`endif
    );

    task automatic set_ch(input int k, input int v);
        in_ch[k*N_B +: N_B] = N_B'(v);
    endtask

    // Queue len expected inc vectors; channels in ch_mask pulse code at first, first+SLOT, ... (count pulses).
    task automatic sb_push(input int len, input int ch_mask, input logic [1:0] code,
                           input int first, input int count);
        for (int i = 1; i <= len; i++) begin
            logic [2*N_CH-1:0] v;
            v = '0;
            for (int c = 0; c < N_CH; c++)
                if (ch_mask[c] && i >= first && ((i - first) % SLOT) == 0 && ((i - first) / SLOT) < count)
                    v[2*c +: 2] = code;
            exp_q.push_back(v);
        end
    endtask

    task automatic apply_reset(input logic [MW-1:0] m, input int ovr,
                               input int c0, input int c1, input int c2, input int c3);
        rst = 1'b1;
        mode = m;
        in_ovr = N_B'(ovr);
        set_ch(0, c0); set_ch(1, c1); set_ch(2, c2); set_ch(3, c3);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mode = 3'd2;
        in_ovr = '0;
        in_ch = '0;
        set_ch(0, 4);
        repeat (2) @(negedge clk);
        n_run++;
        if (inc !== '0) begin n_fail++; $display("FAIL reset_inc: got %b want 0", inc); end
        n_run++;
        if (busy !== '0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef GAIN_STEP_TRACK_EN
        n_run++;
        if (pos !== '0) begin n_fail++; $display("FAIL reset_pos: got %h want 0", pos); end
`endif
        rst = 1'b0;
        sb_push(8, 0, 2'b00, 1, 0);
        cyc_i = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk); cyc_i++; e = exp_q.pop_front(); n_run++;
            if (inc !== e) begin n_fail++; $display("FAIL prime_idle c%0d: inc=%b want %b", cyc_i, inc, e); end
        end
    endtask

    task automatic test_single_channel();
        set_ch(0, 7);
        sb_push(2, 1, UP, 2, 1);
        cyc_i = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk); cyc_i++; e = exp_q.pop_front(); n_run++;
            if (inc !== e) begin n_fail++; $display("FAIL step_first c%0d: inc=%b want %b", cyc_i, inc, e); end
        end
        n_run++;
        if (busy !== 4'b0001) begin n_fail++; $display("FAIL step_busy_mid: got %b want 0001", busy); end
        sb_push(10, 1, UP, 4, 2);
        cyc_i = 2;
        while (exp_q.size() > 0) begin
            @(negedge clk); cyc_i++; e = exp_q.pop_front(); n_run++;
            if (inc !== e) begin n_fail++; $display("FAIL step_rest c%0d: inc=%b want %b", cyc_i, inc, e); end
        end
        n_run++;
        if (busy !== '0) begin n_fail++; $display("FAIL step_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_overall();
        apply_reset(3'd1, 0, 0, 0, 0, 0);
        sb_push(3, 0, 2'b00, 1, 0);
        sb_push(10, 3, DN, 2, 2);
        // The overall source moves in the cycle right after the idle window.
        cyc_i = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk); cyc_i++; e = exp_q.pop_front(); n_run++;
            if (inc !== e) begin n_fail++; $display("FAIL overall c%0d: inc=%b want %b", cyc_i, inc, e); end
            if (cyc_i == 3) in_ovr = -5'sd2;
        end
        n_run++;
        if (busy !== '0) begin n_fail++; $display("FAIL overall_busy: got %b want 0", busy); end
    endtask

    task automatic test_oor();
        apply_reset(3'd4, 0, 0, 0, 5, 0);
        sb_push(3, 0, 2'b00, 1, 0);
        sb_push(4, 0, 2'b00, 1, 0);
        sb_push(8, 4, UP, 2, 1);
        cyc_i = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk); cyc_i++; e = exp_q.pop_front(); n_run++;
            if (inc !== e) begin n_fail++; $display("FAIL oor c%0d: inc=%b want %b", cyc_i, inc, e); end
            if (cyc_i == 3) set_ch(2, 12);
            if (cyc_i == 7) set_ch(2, 6);
        end
        n_run++;
        if (busy !== '0) begin n_fail++; $display("FAIL oor_busy: got %b want 0", busy); end
    endtask

    task automatic test_reverse();
        apply_reset(3'd2, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        set_ch(0, 3);
        sb_push(2, 1, UP, 2, 1);
        sb_push(8, 1, DN, 4, 1);
        cyc_i = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk); cyc_i++; e = exp_q.pop_front(); n_run++;
            if (inc !== e) begin n_fail++; $display("FAIL reverse c%0d: inc=%b want %b", cyc_i, inc, e); end
            if (cyc_i == 2) set_ch(0, 0);
        end
        n_run++;
        if (busy !== '0) begin n_fail++; $display("FAIL reverse_busy: got %b want 0", busy); end
    endtask

    task automatic test_lock();
        apply_reset(3'd2, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        set_ch(0, 3);
        sb_push(2, 1, UP, 2, 1);
        sb_push(8, 0, 2'b00, 1, 0);
        cyc_i = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk); cyc_i++; e = exp_q.pop_front(); n_run++;
            if (inc !== e) begin n_fail++; $display("FAIL lock c%0d: inc=%b want %b", cyc_i, inc, e); end
            if (cyc_i == 3) begin
                n_run++;
                if (busy !== '0) begin n_fail++; $display("FAIL lock_busy: got %b want 0", busy); end
            end
            if (cyc_i == 2) mode = 3'd0;
        end
        // Same drain, but switching to another channel's mode must not stop it.
        apply_reset(3'd2, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        set_ch(0, 3);
        sb_push(2, 1, UP, 2, 1);
        sb_push(9, 1, UP, 4, 2);
        cyc_i = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk); cyc_i++; e = exp_q.pop_front(); n_run++;
            if (inc !== e) begin n_fail++; $display("FAIL modeswitch c%0d: inc=%b want %b", cyc_i, inc, e); end
            if (cyc_i == 2) mode = 3'd3;
        end
        n_run++;
        if (busy !== '0) begin n_fail++; $display("FAIL modeswitch_busy: got %b want 0", busy); end
    endtask

`ifdef GAIN_STEP_TRACK_EN
    task automatic test_track();
        apply_reset(3'd3, 0, 0, -3, 0, 0);
        repeat (2) @(negedge clk);
        set_ch(1, 9);
        sb_push(44, 2, UP, 2, 9);
        cyc_i = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk); cyc_i++; e = exp_q.pop_front(); n_run++;
            if (inc !== e) begin n_fail++; $display("FAIL track c%0d: inc=%b want %b", cyc_i, inc, e); end
        end
        n_run++;
        if (pos[1*N_B +: N_B] !== 5'd9) begin n_fail++; $display("FAIL track_pos: got %0d want 9", $signed(pos[1*N_B +: N_B])); end
        n_run++;
        if (busy !== '0) begin n_fail++; $display("FAIL track_busy: got %b want 0", busy); end
        set_ch(1, -9);
        sb_push(3, 2, DN, 2, 1);
        cyc_i = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk); cyc_i++; e = exp_q.pop_front(); n_run++;
            if (inc !== e) begin n_fail++; $display("FAIL track_down c%0d: inc=%b want %b", cyc_i, inc, e); end
        end
        #2 rst = 1'b1;
        #1;
        n_run++;
        if (inc !== '0 || busy !== '0 || pos !== '0) begin
            n_fail++;
            $display("FAIL track_async_rst: inc=%b busy=%b pos=%h want all 0", inc, busy, pos);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_channel();
        test_overall();
        test_oor();
        test_reverse();
        test_lock();
`ifdef GAIN_STEP_TRACK_EN
        test_track();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
